nonce_gen_mc: RTL and testbench

Multi-lane nonce generator. It loads one 80-byte block header from the 32-bit header stream and computes this core's nonce window. For each nonce it emits an 11-word, 64-bit hash-input packet (marker word, then the header with the nonce substituted) round-robin across NUM_LANES hash cores. Each packet goes to the lane's own hashin FIFO, and the nonce goes to that lane's nonce FIFO. Full lanes are skipped. Stop is packet-atomic, and a done pulse is added.

---
 rtl/nonce_gen_mc.sv | 216 +++++++++++++++++++++
 tb/tb_nonce_gen_mc.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_gen_mc.sv
// Multi-lane nonce generator: loads a block header, derives this core's nonce window
// and streams one marker-prefixed header packet per nonce round-robin over the hash lanes.
module nonce_gen_mc #(
    parameter int NONCE_COEF      = 1,
    parameter int NUM_LANES       = 4,
    parameter int HDR_WORDS       = 20,
    parameter int BYTE_SWAP_NONCE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [31:0]          block_header,
    input  logic                 block_header_we,
    input  logic [31:0]          nonce_size,
    output logic [NUM_LANES-1:0] hashin_fifo_in_we,
    output logic [63:0]          hashin_fifo_in_din,
    input  logic [NUM_LANES-1:0] hashin_fifo_in_full,
    output logic [NUM_LANES-1:0] nonce_fifo_we,
    output logic [31:0]          nonce_fifo_din,
    input  logic [NUM_LANES-1:0] nonce_fifo_full,
    output logic                 stop_ack_nonce,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          nonce_end,
    output logic [31:0]          nonces_issued
);

    localparam int HB = 32 * HDR_WORDS;
    localparam int PW = HDR_WORDS / 2;
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CW = $clog2(HDR_WORDS + 1);
    localparam logic [63:0] MARKER  = 64'h8000000000000280;
    localparam logic [63:0] WIN_MAX = 64'h0000000100000000;

    typedef enum logic [2:0] {INIT, READ_HDR, CALC, SELECT, WRITE_HDR} state_t;

    state_t          state_reg, state_next;
    logic [HB-1:0]   hdr_reg;
    logic [HB-1:0]   sub_hdr_reg;
    logic [32:0]     nonce_reg;
    logic [32:0]     end_reg;
    logic [CW-1:0]   cnt_reg;
    logic [LW-1:0]   rr_reg;
    logic [LW-1:0]   lane_reg;
    logic            stop_seen_reg;
    logic            done_reg;
    logic            stop_ack_reg;
    logic [31:0]     issued_reg;

    logic [63:0]          win_s, win_e;
    logic [32:0]          win_end;
    logic                 win_empty;
    logic [31:0]          nonce_ins;
    logic [NUM_LANES-1:0] lane_free, sel_onehot, cur_onehot;
    logic [LW-1:0]        lane_sel, cand;
    logic                 lane_found;
    logic                 issue;
    logic                 last_word;
    logic [NUM_LANES-1:0] hashin_we_c, nonce_we_c;
    logic [63:0]          hashin_din_c;
    logic [31:0]          nonce_din_c;

    // Window bounds at 64 bits so neither the multiply nor the add can wrap.
    always_comb begin
        win_s     = {32'd0, hdr_reg[31:0]} + 64'(nonce_size) * 64'(NONCE_COEF - 1);
        win_e     = {32'd0, hdr_reg[31:0]} + 64'(nonce_size) * 64'(NONCE_COEF);
        win_end   = (win_e > WIN_MAX) ? WIN_MAX[32:0] : win_e[32:0];
        win_empty = (win_s >= {31'd0, win_end});
    end

    assign nonce_ins = (BYTE_SWAP_NONCE != 0) ?
        {nonce_reg[7:0], nonce_reg[15:8], nonce_reg[23:16], nonce_reg[31:24]} : nonce_reg[31:0];

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        assign lane_free[gi]  = ~hashin_fifo_in_full[gi] & ~nonce_fifo_full[gi];
        assign sel_onehot[gi] = (lane_sel == LW'(gi));
        assign cur_onehot[gi] = (lane_reg == LW'(gi));
    end

    // Scan downward so the lowest offset from rr is the last (winning) assignment.
    always_comb begin
        lane_found = 1'b0;
        lane_sel   = '0;
        cand       = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (int'(rr_reg) + i >= NUM_LANES)
                cand = LW'(int'(rr_reg) + i - NUM_LANES);
            else
                cand = LW'(int'(rr_reg) + i);
            if (lane_free[cand]) begin
                lane_found = 1'b1;
                lane_sel   = cand;
            end
        end
    end

    assign issue     = (state_reg == SELECT) && !stop && (nonce_reg != end_reg) && lane_found;
    assign last_word = (cnt_reg == CW'(PW - 1));

    always_comb begin
        state_next   = state_reg;
        hashin_we_c  = '0;
        hashin_din_c = '0;
        nonce_we_c   = '0;
        nonce_din_c  = '0;
        case (state_reg)
            INIT: begin
                if (start)
                    state_next = READ_HDR;
            end
            READ_HDR: begin
                if (block_header_we && cnt_reg == CW'(HDR_WORDS - 1))
                    state_next = CALC;
            end
            CALC: begin
                state_next = win_empty ? INIT : SELECT;
            end
            SELECT: begin
                if (stop || nonce_reg == end_reg) begin
                    state_next = INIT;
                end else if (lane_found) begin
                    hashin_we_c  = sel_onehot;
                    hashin_din_c = MARKER;
                    nonce_we_c   = sel_onehot;
                    nonce_din_c  = nonce_reg[31:0];
                    state_next   = WRITE_HDR;
                end
            end
            WRITE_HDR: begin
                hashin_din_c = sub_hdr_reg[HB-1 -: 64];
                if (!hashin_fifo_in_full[lane_reg]) begin
                    hashin_we_c = cur_onehot;
                    if (last_word)
                        state_next = (stop_seen_reg || stop) ? INIT : SELECT;
                end
            end
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= INIT;
            hdr_reg       <= '0;
            sub_hdr_reg   <= '0;
            nonce_reg     <= '0;
            end_reg       <= '0;
            cnt_reg       <= '0;
            rr_reg        <= '0;
            lane_reg      <= '0;
            stop_seen_reg <= 1'b0;
            done_reg      <= 1'b0;
            stop_ack_reg  <= 1'b0;
            issued_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            // Every return to INIT from an active state ends the job.
            done_reg     <= (state_reg != INIT) && (state_next == INIT);
            stop_ack_reg <= (state_reg == INIT) && !start;
            case (state_reg)
                INIT: begin
                    hdr_reg       <= '0;
                    nonce_reg     <= '0;
                    cnt_reg       <= '0;
                    rr_reg        <= '0;
                    stop_seen_reg <= 1'b0;
                    if (start)
                        issued_reg <= '0;
                end
                READ_HDR: begin
                    if (block_header_we) begin
                        hdr_reg <= {block_header, hdr_reg[HB-1:32]};
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                CALC: begin
                    end_reg   <= win_end;
                    nonce_reg <= win_s[32:0];
                    cnt_reg   <= '0;
                end
                SELECT: begin
                    if (issue) begin
                        sub_hdr_reg   <= {hdr_reg[HB-1:32], nonce_ins};
                        nonce_reg     <= nonce_reg + 1'b1;
                        issued_reg    <= issued_reg + 1'b1;
                        rr_reg        <= (int'(lane_sel) == NUM_LANES - 1) ? '0 : lane_sel + 1'b1;
                        lane_reg      <= lane_sel;
                        cnt_reg       <= '0;
                        stop_seen_reg <= 1'b0;
                    end
                end
                WRITE_HDR: begin
                    if (stop)
                        stop_seen_reg <= 1'b1;
                    if (!hashin_fifo_in_full[lane_reg]) begin
                        sub_hdr_reg <= sub_hdr_reg << 64;
                        cnt_reg     <= cnt_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hashin_fifo_in_we  = hashin_we_c;
    assign hashin_fifo_in_din = hashin_din_c;
    assign nonce_fifo_we      = nonce_we_c;
    assign nonce_fifo_din     = nonce_din_c;
    assign stop_ack_nonce     = stop_ack_reg;
    assign busy               = (state_reg != INIT);
    assign done               = done_reg;
    assign nonce_end          = end_reg[31:0];
    assign nonces_issued      = issued_reg;

endmodule

// File: tb/tb_nonce_gen_mc.sv
// Bench for nonce_gen_mc: window/packet model checked against a stream monitor,
// with a NONCE_COEF=2 instance alongside for window arithmetic.
module tb_nonce_gen_mc;

    localparam int NL = 4;
    localparam int HW = 20;
    localparam int PW = HW / 2;
    localparam logic [63:0] MARKER = 64'h8000000000000280;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, stop = 1'b0, block_header_we = 1'b0;
    logic [31:0] block_header = '0, nonce_size = '0;
    logic [NL-1:0] hfull_man = '0, hfull_rnd = '0, nfull_rnd = '0;
    logic [NL-1:0] hashin_fifo_in_full, nonce_fifo_full;
    logic rand_en = 1'b0;

    logic [NL-1:0] h_we, n_we, h_we2, n_we2;
    logic [63:0]   h_din, h_din2;
    logic [31:0]   n_din, n_din2, nonce_end, nonce_end2, issued, issued2;
    logic          stop_ack, stop_ack2, busy, busy2, done, done2;

    assign hashin_fifo_in_full = hfull_man | hfull_rnd;
    assign nonce_fifo_full     = nfull_rnd;

    nonce_gen_mc #(.NONCE_COEF(1), .NUM_LANES(NL), .HDR_WORDS(HW), .BYTE_SWAP_NONCE(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .block_header(block_header), .block_header_we(block_header_we), .nonce_size(nonce_size),
        .hashin_fifo_in_we(h_we), .hashin_fifo_in_din(h_din), .hashin_fifo_in_full(hashin_fifo_in_full),
        .nonce_fifo_we(n_we), .nonce_fifo_din(n_din), .nonce_fifo_full(nonce_fifo_full),
        .stop_ack_nonce(stop_ack), .busy(busy), .done(done),
        .nonce_end(nonce_end), .nonces_issued(issued));

    nonce_gen_mc #(.NONCE_COEF(2), .NUM_LANES(NL), .HDR_WORDS(HW), .BYTE_SWAP_NONCE(1)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .block_header(block_header), .block_header_we(block_header_we), .nonce_size(nonce_size),
        .hashin_fifo_in_we(h_we2), .hashin_fifo_in_din(h_din2), .hashin_fifo_in_full(hashin_fifo_in_full),
        .nonce_fifo_we(n_we2), .nonce_fifo_din(n_din2), .nonce_fifo_full(nonce_fifo_full),
        .stop_ack_nonce(stop_ack2), .busy(busy2), .done(done2),
        .nonce_end(nonce_end2), .nonces_issued(issued2));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0, checks = 0;

    function automatic void chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endfunction

    // Reference expectations for the COEF=1 instance
    logic [31:0] hw [HW];
    logic [63:0] exp_words[$];
    logic [31:0] exp_nonces[$];

    // Monitor state
    int word_idx, rr_m, cur_lane, lane_m, exp_lane, idx_m;
    int pkt_lane[$], pkt_start[$], pkt_end[$];
    int wr2_cnt, done_cnt, done2_cnt, done_cyc;
    logic ack_at_done;

    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                ack_at_done = stop_ack;
            end
            if (done2) done2_cnt++;
            if (h_we2 != 0) wr2_cnt++;
            if (h_we != 0) begin
                lane_m = 0;
                for (int i = NL - 1; i >= 0; i--) if (h_we[i]) lane_m = i;
                chk($onehot(h_we), "we_onehot", 64'(h_we), 64'(1 << lane_m));
                chk(!hashin_fifo_in_full[lane_m], "write_to_full_lane", 64'(lane_m), 64'(hashin_fifo_in_full));
                chk(exp_words.size() != 0, "unexpected_write", h_din, 64'd0);
                if (exp_words.size() != 0) begin
                    if (word_idx == 0) begin
                        exp_lane = -1;
                        for (int i = 0; i < NL; i++) begin
                            idx_m = (rr_m + i) % NL;
                            if (exp_lane < 0 && !hashin_fifo_in_full[idx_m] && !nonce_fifo_full[idx_m])
                                exp_lane = idx_m;
                        end
                        chk(lane_m == exp_lane, "marker_lane", 64'(lane_m), 64'(exp_lane));
                        chk(n_we == h_we, "nonce_we", 64'(n_we), 64'(h_we));
                        chk(n_din == exp_nonces[0], "nonce_din", 64'(n_din), 64'(exp_nonces[0]));
                        void'(exp_nonces.pop_front());
                        cur_lane = lane_m;
                        rr_m = (lane_m + 1) % NL;
                        pkt_lane.push_back(lane_m);
                        pkt_start.push_back(cyc);
                    end else begin
                        chk(lane_m == cur_lane, "word_lane", 64'(lane_m), 64'(cur_lane));
                        chk(n_we == 0, "nonce_we_mid_packet", 64'(n_we), 64'd0);
                    end
                    chk(h_din == exp_words[0], $sformatf("din_w%0d", word_idx), h_din, exp_words[0]);
                    void'(exp_words.pop_front());
                    if (word_idx == PW) pkt_end.push_back(cyc);
                    word_idx = (word_idx == PW) ? 0 : word_idx + 1;
                end
            end else begin
                chk(n_we == 0, "nonce_we_alone", 64'(n_we), 64'd0);
            end
        end
    end

    // Random backpressure, changed just after the active edge
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NL; i++) begin
            hfull_rnd[i] = rand_en && ($urandom_range(0, 3) == 0);
            nfull_rnd[i] = rand_en && ($urandom_range(0, 4) == 0);
        end
    end

    function automatic logic [31:0] bswap(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    // Window and packet contents straight from the arithmetic rules.
    task automatic build_model(output int cnt, output logic [31:0] endv);
        logic [63:0] s, e, w;
        logic [31:0] nv, hi, lo;
        s = {32'd0, hw[0]};
        e = {32'd0, hw[0]} + {32'd0, nonce_size};
        if (e > 64'h1_0000_0000) e = 64'h1_0000_0000;
        endv = e[31:0];
        cnt = (s < e) ? int'(e - s) : 0;
        for (int n = 0; n < cnt; n++) begin
            nv = hw[0] + 32'(n);
            exp_nonces.push_back(nv);
            exp_words.push_back(MARKER);
            for (int k = 0; k < PW; k++) begin
                hi = (HW - 1 - 2 * k == 0) ? bswap(nv) : hw[HW - 1 - 2 * k];
                lo = (HW - 2 - 2 * k == 0) ? bswap(nv) : hw[HW - 2 - 2 * k];
                w = {hi, lo};
                exp_words.push_back(w);
            end
        end
    endtask

    task automatic clear_mon();
        exp_words.delete(); exp_nonces.delete();
        pkt_lane.delete(); pkt_start.delete(); pkt_end.delete();
        word_idx = 0; rr_m = 0; cur_lane = 0;
        wr2_cnt = 0; done_cnt = 0; done2_cnt = 0; done_cyc = -1; ack_at_done = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; stop = 1'b0; block_header_we = 1'b0; hfull_man = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic load_hdr(input logic [31:0] w0, input logic [31:0] sz, input bit gaps);
        hw[0] = w0;
        for (int j = 1; j < HW; j++) hw[j] = $urandom;
        nonce_size = sz;
        @(posedge clk); #1;
        start = 1'b1; block_header = 32'hDEADBEEF; block_header_we = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; block_header_we = 1'b0;
        for (int j = 0; j < HW; j++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
            end
            block_header = hw[j]; block_header_we = 1'b1;
            @(posedge clk); #1;
            block_header_we = 1'b0;
        end
    endtask

    task automatic wait_done(input int budget, input bit both);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk);
            if (done_cnt > 0 && (!both || done2_cnt > 0)) ok = 1'b1;
        end
        chk(ok, "done_timeout", 64'(done_cnt), 64'd1);
    endtask

    task automatic wait_pkts(input int n);
        bit ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(posedge clk);
            if (pkt_lane.size() >= n) ok = 1'b1;
        end
        chk(ok, "packet_timeout", 64'(pkt_lane.size()), 64'(n));
    endtask

    task automatic finish_test(input string tag, input int cnt, input logic [31:0] endv);
        repeat (2) @(posedge clk);
        #1;
        chk(exp_words.size() == 0, {tag, "_words_left"}, 64'(exp_words.size()), 64'd0);
        chk(issued == 32'(cnt), {tag, "_nonces_issued"}, 64'(issued), 64'(cnt));
        chk(nonce_end == endv, {tag, "_nonce_end"}, 64'(nonce_end), 64'(endv));
        chk(done_cnt == 1, {tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        chk(busy == 1'b0, {tag, "_busy_idle"}, 64'(busy), 64'd0);
        chk(stop_ack == 1'b1, {tag, "_stop_ack_idle"}, 64'(stop_ack), 64'd1);
        $display("test %s: nonces=%0d end=%h packets=%0d", tag, issued, nonce_end, pkt_lane.size());
    endtask

    task automatic run_basic(input string tag, input bit reset_first);
        int cnt;
        logic [31:0] endv;
        if (reset_first) do_reset();
        load_hdr(32'h00000010, 32'd3, 1'b0);
        build_model(cnt, endv);
        wait_done(1000, 1'b0);
        finish_test(tag, 3, 32'h00000013);
        chk(pkt_lane.size() == 3, {tag, "_packets"}, 64'(pkt_lane.size()), 64'd3);
        for (int i = 0; i < 3 && i < pkt_lane.size(); i++)
            chk(pkt_lane[i] == i, {tag, "_lane"}, 64'(pkt_lane[i]), 64'(i));
        if (pkt_end.size() == 3) begin
            chk(pkt_end[2] - pkt_start[0] == 32, {tag, "_burst_cycles"}, 64'(pkt_end[2] - pkt_start[0]), 64'd32);
            chk(done_cyc == pkt_end[2] + 2, {tag, "_done_cycle"}, 64'(done_cyc), 64'(pkt_end[2] + 2));
        end
    endtask

    typedef struct {
        logic [31:0] w0;
        logic [31:0] sz;
        int          cnt;
        logic [31:0] endv;
        int          cnt2;
        logic [31:0] end2;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int cnt;
        logic [31:0] endv, w0;

        vecs[0] = '{32'h00000010, 32'd3,    3, 32'h00000013, 3, 32'h00000016};
        vecs[1] = '{32'hFFFFFFFE, 32'd5,    2, 32'h00000000, 0, 32'h00000000};
        vecs[2] = '{32'h00000005, 32'd0,    0, 32'h00000005, 0, 32'h00000005};
        vecs[3] = '{32'hFFFFFFFF, 32'd1,    1, 32'h00000000, 0, 32'h00000000};
        vecs[4] = '{32'h7FFFFFF0, 32'd2,    2, 32'h7FFFFFF2, 2, 32'h7FFFFFF4};
        vecs[5] = '{32'h00000000, 32'd1,    1, 32'h00000001, 1, 32'h00000002};
        vecs[6] = '{32'hFFFFFFF0, 32'h20,  16, 32'h00000000, 0, 32'h00000000};

        clear_mon();
        // Reset values while rst is held, before any clock edge
        #2 rst = 1'b1;
        #1;
        chk(h_we == 0 && n_we == 0, "rst_we", 64'({h_we, n_we}), 64'd0);
        chk(h_din == 0, "rst_hashin_din", h_din, 64'd0);
        chk(n_din == 0, "rst_nonce_din", 64'(n_din), 64'd0);
        chk({busy, done, stop_ack} == 3'b000, "rst_flags", 64'({busy, done, stop_ack}), 64'd0);
        chk(nonce_end == 0 && issued == 0, "rst_counters", {nonce_end, issued}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk(stop_ack == 1'b0, "stop_ack_before_edge", 64'(stop_ack), 64'd0);
        @(posedge clk); #1;
        chk(stop_ack == 1'b1, "stop_ack_after_edge", 64'(stop_ack), 64'd1);
        $display("test reset: stop_ack=%0d busy=%0d", stop_ack, busy);

        run_basic("basic", 1'b1);

        // Table: window arithmetic for both NONCE_COEF instances
        for (int v = 0; v < 7; v++) begin
            do_reset();
            load_hdr(vecs[v].w0, vecs[v].sz, 1'b1);
            build_model(cnt, endv);
            wait_done(3000, 1'b1);
            finish_test($sformatf("vec%0d", v), vecs[v].cnt, vecs[v].endv);
            chk(issued2 == 32'(vecs[v].cnt2), "coef2_issued", 64'(issued2), 64'(vecs[v].cnt2));
            chk(nonce_end2 == vecs[v].end2, "coef2_nonce_end", 64'(nonce_end2), 64'(vecs[v].end2));
            chk(wr2_cnt == vecs[v].cnt2 * (PW + 1), "coef2_writes", 64'(wr2_cnt), 64'(vecs[v].cnt2 * (PW + 1)));
            chk(done2_cnt == 1, "coef2_done", 64'(done2_cnt), 64'd1);
        end

        // Lane 1 always full; lane 2 stalls mid-packet; stray start is ignored
        do_reset();
        hfull_man = 4'b0010;
        load_hdr(32'h00000100, 32'd4, 1'b0);
        build_model(cnt, endv);
        wait_pkts(2);
        @(posedge clk); #1;
        hfull_man[2] = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        hfull_man[2] = 1'b0;
        wait_done(1000, 1'b0);
        hfull_man = '0;
        finish_test("skip_stall", 4, 32'h00000104);
        chk(pkt_lane.size() == 4, "skip_packets", 64'(pkt_lane.size()), 64'd4);
        if (pkt_lane.size() == 4) begin
            chk(pkt_lane[0] == 0 && pkt_lane[1] == 2 && pkt_lane[2] == 3 && pkt_lane[3] == 0,
                "skip_lanes", 64'({pkt_lane[0], pkt_lane[1], pkt_lane[2], pkt_lane[3]}), 64'h0000000000000000 | 64'(32'h0203_0000) >> 16);
            chk(pkt_end[0] - pkt_start[0] == 10, "pkt1_cycles", 64'(pkt_end[0] - pkt_start[0]), 64'd10);
            chk(pkt_end[1] - pkt_start[1] == 15, "stall_pkt_cycles", 64'(pkt_end[1] - pkt_start[1]), 64'd15);
        end

        // Stop during word 4 of packet 2: packet completes, no third packet
        do_reset();
        load_hdr(32'h00000200, 32'd5, 1'b0);
        build_model(cnt, endv);
        wait_pkts(2);
        repeat (3) @(posedge clk);
        #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        wait_done(500, 1'b0);
        #1;
        chk(pkt_end.size() == 2 && pkt_lane.size() == 2, "stop_packets", 64'(pkt_lane.size()), 64'd2);
        if (pkt_end.size() == 2) begin
            chk(pkt_end[1] - pkt_start[1] == 10, "stop_pkt_cycles", 64'(pkt_end[1] - pkt_start[1]), 64'd10);
            chk(done_cyc == pkt_end[1] + 1, "stop_done_cycle", 64'(done_cyc), 64'(pkt_end[1] + 1));
        end
        chk(ack_at_done == 1'b0, "stop_ack_at_done", 64'(ack_at_done), 64'd0);
        chk(stop_ack == 1'b1, "stop_ack_after_done", 64'(stop_ack), 64'd1);
        chk(issued == 2, "stop_issued", 64'(issued), 64'd2);
        chk(exp_words.size() == 3 * (PW + 1), "stop_unsent", 64'(exp_words.size()), 64'(3 * (PW + 1)));
        $display("test stop: packets=%0d issued=%0d", pkt_lane.size(), issued);

        // Asynchronous reset in the middle of a packet
        do_reset();
        load_hdr(32'h00000010, 32'd3, 1'b0);
        build_model(cnt, endv);
        wait_pkts(1);
        repeat (3) @(posedge clk);
        #2;
        chk(h_we != 0, "pre_reset_writing", 64'(h_we), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk(h_we == 0 && n_we == 0, "midrst_we", 64'({h_we, n_we}), 64'd0);
        chk(h_din == 0 && n_din == 0, "midrst_din", h_din | 64'(n_din), 64'd0);
        chk({busy, done, stop_ack} == 3'b000, "midrst_flags", 64'({busy, done, stop_ack}), 64'd0);
        chk(nonce_end == 0 && issued == 0, "midrst_counters", {nonce_end, issued}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_mon();
        run_basic("after_rst", 1'b0);

        // Randomised headers and backpressure against the model
        for (int r = 0; r < 8; r++) begin
            do_reset();
            w0 = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF - 32'($urandom_range(0, 4)) : $urandom;
            rand_en = 1'b1;
            load_hdr(w0, 32'($urandom_range(0, 6)), 1'b1);
            build_model(cnt, endv);
            wait_done(4000, 1'b0);
            rand_en = 1'b0;
            finish_test($sformatf("rand%0d", r), cnt, endv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
